// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, bit-period derivation and
// the FSM state encoding used by both the receiver and the transmitter.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 9600;
  localparam int CNT_W        = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_bit_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud - 1;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input po_data, po_flag, frame_err, busy);
  modport slave  (input rx, output po_data, po_flag, frame_err, busy);
endinterface

// File: rtl/uart_sync.sv
// Three-flop synchroniser for the asynchronous rx line plus falling-edge detect.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic s2,
  output logic start_edge
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Idle-high line: reset to 1 so releasing reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= rx;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign s2         = s2_r;
  assign start_edge = s3_r & ~s2_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, strobes good bytes and framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam int BIT_CNT_MAX = calc_bit_cnt_max(CLK_FREQ, BAUD);
  localparam int HALF_CNT    = calc_half_cnt(CLK_FREQ, BAUD);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT);

  uart_state_e      state_r;
  uart_state_e      state_nxt_s;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             flag_r;
  logic             err_r;
  logic             busy_r;
  logic             s2_s;
  logic             start_s;
  logic             bit_done_s;
  logic             good_s;
  logic             bad_s;

  uart_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (bus.rx),
    .s2        (s2_s),
    .start_edge(start_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; STOP exits at mid-bit so back-to-back frames have no dead time
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_s) state_nxt_s = START; else state_nxt_s = IDLE;
      START:   if (baud_cnt_r == HALF_LAST) state_nxt_s = s2_s ? IDLE : DATA;
               else state_nxt_s = START;
      DATA:    if ((baud_cnt_r == BIT_LAST) && (bit_idx_r == 3'd7)) state_nxt_s = STOP;
               else state_nxt_s = DATA;
      STOP:    if (baud_cnt_r == BIT_LAST) state_nxt_s = IDLE; else state_nxt_s = STOP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sample-point decode feeding the registered outputs
  always_comb begin
    bit_done_s = 1'b0;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    case (state_r)
      DATA: begin
        bit_done_s = (baud_cnt_r == BIT_LAST);
      end
      STOP: begin
        good_s = (baud_cnt_r == BIT_LAST) &&  s2_s;
        bad_s  = (baud_cnt_r == BIT_LAST) && !s2_s;
      end
      default: begin
        bit_done_s = 1'b0;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
    end else begin
      if ((state_nxt_s != state_r) || (state_r == IDLE) || bit_done_s) begin
        baud_cnt_r <= {CNT_W{1'b0}};
      end else begin
        baud_cnt_r <= baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state_r != DATA) begin
        bit_idx_r <= 3'd0;
      end else if (bit_done_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (bit_done_s) begin
        shift_r <= {s2_s, shift_r[7:1]};
      end
    end
  end

  // Registered outputs; busy tracks the state the FSM is entering
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 8'h00;
      flag_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      flag_r <= good_s;
      err_r  <= bad_s;
      busy_r <= (state_nxt_s != IDLE);
      if (good_s) begin
        data_r <= shift_r;
      end
    end
  end

  assign bus.po_data   = data_r;
  assign bus.po_flag   = flag_r;
  assign bus.frame_err = err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a frame-level model predicts each strobe's kind,
// byte and arrival cycle from the line timing rules.
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = (BIT - 1) / 2;
  localparam int LAT      = 3 + (HALF + 1) + 9 * BIT + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    n_checks++;
    d = (obs > exp) ? obs - exp : exp - obs;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d at cycle %0d",
               tag, obs, obs, exp, exp, tol, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe monitor: each strobe must match the oldest predicted frame outcome
  always @(negedge clk) begin
    if (rst_n && (bus.po_flag || bus.frame_err)) begin
      check_val("flag_err_exclusive", int'(bus.po_flag & bus.frame_err), 0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_strobe", exp_q.size(), 1);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_val("strobe_is_err", int'(bus.frame_err), int'(e.is_err));
        check_val("strobe_latency", cyc, e.t, 1);
        if (!e.is_err) last_good = e.data;
        check_val("po_data", int'(bus.po_data), int'(last_good));
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit stop, input int gap);
    bus.rx = 1'b0;
    exp_q.push_back('{is_err: !stop, data: d, t: cyc + LAT});
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_cyc(BIT);
    end
    bus.rx = stop;
    wait_cyc(BIT);
    bus.rx = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic glitch(input int len);
    bus.rx = 1'b0;
    for (int k = 0; k < HALF + 16; k++) begin
      if (k == len) bus.rx = 1'b1;
      if (k == 5) check_val("glitch_busy_rise", int'(bus.busy), 1);
      wait_cyc(1);
    end
    check_val("glitch_busy_fall", int'(bus.busy), 0);
  endtask

  initial begin
    logic [7:0] rb;
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    wait_cyc(3);
    check_val("reset_po_data", int'(bus.po_data), 0);
    check_val("reset_po_flag", int'(bus.po_flag), 0);
    check_val("reset_frame_err", int'(bus.frame_err), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    wait_cyc(5);
    check_val("idle_busy", int'(bus.busy), 0);

    send_frame(8'h55, 1'b1, 20);
    check_val("busy_after_frame", int'(bus.busy), 0);
    check_val("data_55", int'(bus.po_data), 8'h55);

    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 20);
    check_val("data_3c", int'(bus.po_data), 8'h3C);

    send_frame(8'hF0, 1'b0, 20);
    check_val("ferr_keeps_data", int'(bus.po_data), 8'h3C);

    glitch(15);

    // Break: one long low period yields exactly one framing error
    bus.rx = 1'b0;
    exp_q.push_back('{is_err: 1'b1, data: 8'h00, t: cyc + LAT});
    wait_cyc(20 * BIT);
    bus.rx = 1'b1;
    wait_cyc(3 * BIT);
    check_val("break_single_err", exp_q.size(), 0);
    send_frame(8'h81, 1'b1, 20);
    check_val("data_81", int'(bus.po_data), 8'h81);

    // Reset asserted in the middle of data bit 4
    rb = 8'h6E;
    bus.rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = rb[i];
      wait_cyc(BIT);
    end
    bus.rx = rb[4];
    wait_cyc(BIT / 2);
    rst_n = 1'b0;
    wait_cyc(2);
    check_val("midrst_po_data", int'(bus.po_data), 0);
    check_val("midrst_po_flag", int'(bus.po_flag), 0);
    check_val("midrst_frame_err", int'(bus.frame_err), 0);
    check_val("midrst_busy", int'(bus.busy), 0);
    bus.rx = 1'b1;
    last_good = 8'h00;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(12 * BIT);
    check_val("midrst_no_strobe_data", int'(bus.po_data), 0);
    send_frame(8'hC7, 1'b1, 20);
    check_val("data_after_rst", int'(bus.po_data), 8'hC7);

    // Random traffic: bytes, stop bits, gaps and interleaved glitches
    for (int n = 0; n < 30; n++) begin
      bit st;
      int gap;
      st  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 30);
      if (!st && gap < 4) gap = 4;
      send_frame(8'($urandom), st, gap);
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, HALF - 4));
    end

    wait_cyc(LAT + BIT);
    check_val("missing_strobes", exp_q.size(), 0);
    check_val("final_po_data", int'(bus.po_data), int'(last_good));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
